// File: rtl/mips32_pkg.sv
// Shared opcodes, FSM states and scoreboard entry layout for the pipe_MIPS32 hazard controller.
package mips32_pkg;

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_AND   = 6'd2;
    localparam logic [5:0] OP_OR    = 6'd3;
    localparam logic [5:0] OP_SLT   = 6'd4;
    localparam logic [5:0] OP_MUL   = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd8;
    localparam logic [5:0] OP_SW    = 6'd9;
    localparam logic [5:0] OP_ADDI  = 6'd10;
    localparam logic [5:0] OP_SUBI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_BNEQZ = 6'd13;
    localparam logic [5:0] OP_BEQZ  = 6'd14;
    localparam logic [5:0] OP_HLT   = 6'd63;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned SB_DEPTH = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // One scoreboard slot per downstream pipeline register: ID/EX, EX/MEM, MEM/WB.
    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] dest;
    } sb_entry_t;

    localparam int unsigned SB_ENTRY_W = $bits(sb_entry_t);

    function automatic logic sb_hit(input sb_entry_t e, input logic [REG_AW-1:0] r);
        return e.v && (e.dest == r);
    endfunction

endpackage

// File: rtl/mips32_reg_usage.sv
// Combinational decode of an IF/ID instruction into register read/write usage.
module mips32_reg_usage
    import mips32_pkg::*;
(
    input  logic [31:0]       ir_i,
    output logic              uses_rs_o,
    output logic              uses_rt_o,
    output logic [REG_AW-1:0] rs_o,
    output logic [REG_AW-1:0] rt_o,
    output logic              has_dest_o,
    output logic [REG_AW-1:0] dest_o,
    output logic              is_hlt_o
);

    logic [5:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] dest_raw;
    logic              dest_en;
    logic              unused_imm;

    assign op         = ir_i[31:26];
    assign rs_o       = ir_i[25:21];
    assign rt_o       = ir_i[20:16];
    assign rd         = ir_i[15:11];
    assign unused_imm = ^ir_i[10:0];

    always_comb begin
        uses_rs_o = 1'b0;
        uses_rt_o = 1'b0;
        dest_en   = 1'b0;
        dest_raw  = '0;
        is_hlt_o  = 1'b0;
        unique case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
                uses_rs_o = 1'b1;
                uses_rt_o = 1'b1;
                dest_en   = 1'b1;
                dest_raw  = rd;
            end
            OP_ADDI, OP_SUBI, OP_SLTI, OP_LW: begin
                uses_rs_o = 1'b1;
                dest_en   = 1'b1;
                dest_raw  = rt_o;
            end
            OP_SW: begin
                uses_rs_o = 1'b1;
                uses_rt_o = 1'b1;
            end
            OP_BNEQZ, OP_BEQZ: begin
                uses_rs_o = 1'b1;
            end
            OP_HLT: begin
                is_hlt_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // R0 is hard-wired zero, so writing it never creates a dependency.
    assign has_dest_o = dest_en && (dest_raw != '0);
    assign dest_o     = has_dest_o ? dest_raw : '0;

endmodule

// File: rtl/mips32_hazard_ctrl.sv
// Interlock scheduler for the 5-stage pipe_MIPS32: RAW stalls, branch flush and HLT drain.
module mips32_hazard_ctrl
    import mips32_pkg::*;
#(
    parameter bit          WB_BYPASS = 1'b0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ifid_ir,
    input  logic             ifid_valid,
    input  logic             br_taken,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e                     state_q, state_d;
    sb_entry_t [SB_DEPTH-1:0]   sb_q, sb_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    logic              uses_rs, uses_rt, has_dest, is_hlt;
    logic [REG_AW-1:0] rs, rt, dest;
    logic              hit_rs, hit_rt, hazard;
    logic              flush_act, raw_stall, issue;

    mips32_reg_usage u_usage (
        .ir_i       (ifid_ir),
        .uses_rs_o  (uses_rs),
        .uses_rt_o  (uses_rt),
        .rs_o       (rs),
        .rt_o       (rt),
        .has_dest_o (has_dest),
        .dest_o     (dest),
        .is_hlt_o   (is_hlt)
    );

    // With write-before-read the MEM/WB producer is already visible to the reader.
    assign hit_rs = sb_hit(sb_q[0], rs) || sb_hit(sb_q[1], rs) ||
                    (!WB_BYPASS && sb_hit(sb_q[2], rs));
    assign hit_rt = sb_hit(sb_q[0], rt) || sb_hit(sb_q[1], rt) ||
                    (!WB_BYPASS && sb_hit(sb_q[2], rt));
    assign hazard = ifid_valid && ((uses_rs && hit_rs) || (uses_rt && hit_rt));

    assign flush_act = br_taken && (state_q != ST_HALT);

    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        raw_stall   = 1'b0;
        issue       = 1'b0;
        if (flush_act) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        idex_bubble = 1'b1;
                        raw_stall   = 1'b1;
                    end else begin
                        issue = ifid_valid;
                    end
                end
                default: begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                end
            endcase
        end
    end

    assign halted    = (state_q == ST_HALT);
    assign stall_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (issue && is_hlt) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (br_taken)
                    state_d = ST_RUN;
                else if (!sb_q[1].v && !sb_q[2].v)
                    state_d = ST_HALT;
            end
            default:  state_d = state_q;
        endcase
    end

    // A flushed ID/EX slot is wrong-path, so it must not age into EX/MEM.
    always_comb begin
        sb_d[0] = issue ? sb_entry_t'{v: has_dest, dest: dest} : '0;
        sb_d[1] = flush_act ? '0 : sb_q[0];
        sb_d[2] = sb_q[1];
    end

    assign cnt_d = (raw_stall && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            sb_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mips32_hazard_ctrl.sv
// Vector-driven bench for mips32_hazard_ctrl: one instance without and one with WB bypass.
module tb_mips32_hazard_ctrl;

    localparam logic [4:0] O_NONE  = 5'b00000;
    localparam logic [4:0] O_STALL = 5'b11100;
    localparam logic [4:0] O_FLUSH = 5'b00110;
    localparam logic [4:0] O_HALT  = 5'b11101;

    typedef struct {
        bit          which;
        logic        rst;
        logic        valid;
        logic [31:0] ir;
        logic        br;
        logic [4:0]  o;
        logic [15:0] cnt;
        string       name;
    } vec_t;

    typedef struct {
        bit          which;
        int          idx;
        logic [4:0]  o;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1, valid0 = 1'b0, br0 = 1'b0;
    logic [31:0] ir0 = '0;
    logic        ph0, ih0, bb0, fl0, ht0;
    logic [15:0] cnt0;

    logic        rst1 = 1'b1, valid1 = 1'b0, br1 = 1'b0;
    logic [31:0] ir1 = '0;
    logic        ph1, ih1, bb1, fl1, ht1;
    logic [1:0]  cnt1;

    mips32_hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst0), .ifid_ir(ir0), .ifid_valid(valid0), .br_taken(br0),
        .pc_hold(ph0), .ifid_hold(ih0), .idex_bubble(bb0), .ifid_flush(fl0),
        .halted(ht0), .stall_cnt(cnt0)
    );

    mips32_hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst1), .ifid_ir(ir1), .ifid_valid(valid1), .br_taken(br1),
        .pc_hold(ph1), .ifid_hold(ih1), .idex_bubble(bb1), .ifid_flush(fl1),
        .halted(ht1), .stall_cnt(cnt1)
    );

    function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic void v(input bit which, input logic rst, input logic valid,
                              input logic [31:0] ir, input logic br, input logic [4:0] o,
                              input int cnt, input string name);
        vec_t t;
        t.which = which; t.rst = rst; t.valid = valid; t.ir = ir; t.br = br;
        t.o = o; t.cnt = 16'(cnt); t.name = name;
        vecs.push_back(t);
    endfunction

    task automatic apply(input vec_t t);
        if (t.which == 1'b0) begin
            rst0 = t.rst; valid0 = t.valid; ir0 = t.ir; br0 = t.br;
            rst1 = 1'b1;  valid1 = 1'b0;    ir1 = '0;   br1 = 1'b0;
        end else begin
            rst1 = t.rst; valid1 = t.valid; ir1 = t.ir; br1 = t.br;
            rst0 = 1'b1;  valid0 = 1'b0;    ir0 = '0;   br0 = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t        e;
            logic [4:0]  got_o;
            logic [15:0] got_c;
            e     = exp_q.pop_front();
            got_o = e.which ? {ph1, ih1, bb1, fl1, ht1} : {ph0, ih0, bb0, fl0, ht0};
            got_c = e.which ? {14'd0, cnt1} : cnt0;
            checks++;
            if (got_o !== e.o) begin
                errors++;
                $display("FAIL %s[%0d] outputs {pc_hold,ifid_hold,idex_bubble,ifid_flush,halted}: got %b want %b",
                         e.name, e.idx, got_o, e.o);
            end
            checks++;
            if (got_c !== e.cnt) begin
                errors++;
                $display("FAIL %s[%0d] stall_cnt: got %0d want %0d", e.name, e.idx, got_c, e.cnt);
            end
        end
    end

    initial begin
        logic [31:0] hlt, add_r4_r1_r2, sub_r6, add_r10, add_r14, add_r4_r3, add_r6_r5;
        hlt          = {6'd63, 26'd0};
        add_r4_r1_r2 = rr(6'd0, 5'd4, 5'd1, 5'd2);
        sub_r6       = rr(6'd1, 5'd6, 5'd5, 5'd3);
        add_r10      = rr(6'd0, 5'd10, 5'd9, 5'd9);
        add_r14      = rr(6'd0, 5'd14, 5'd13, 5'd13);
        add_r4_r3    = rr(6'd0, 5'd4, 5'd3, 5'd3);
        add_r6_r5    = rr(6'd0, 5'd6, 5'd5, 5'd5);

        // WB_BYPASS=0 instance
        v(0, 1, 0, '0, 0, O_NONE, 0, "reset");
        v(0, 0, 0, '0, 0, O_NONE, 0, "idle");
        v(0, 0, 1, ri(6'd10, 5'd2, 5'd0, 16'd20), 0, O_NONE, 0, "addi_r2");
        v(0, 0, 1, add_r4_r1_r2, 0, O_STALL, 0, "raw_b1");
        v(0, 0, 1, add_r4_r1_r2, 0, O_STALL, 1, "raw_b2");
        v(0, 0, 1, add_r4_r1_r2, 0, O_STALL, 2, "raw_b3");
        v(0, 0, 1, add_r4_r1_r2, 0, O_NONE, 3, "raw_issue");
        v(0, 0, 1, ri(6'd10, 5'd0, 5'd0, 16'd5), 0, O_NONE, 3, "addi_r0");
        v(0, 0, 1, rr(6'd0, 5'd4, 5'd0, 5'd0), 0, O_NONE, 3, "add_r0_r0");
        v(0, 0, 1, ri(6'd10, 5'd5, 5'd0, 16'd7), 0, O_NONE, 3, "addi_r5");
        v(0, 0, 1, ri(6'd9, 5'd3, 5'd1, 16'd0), 0, O_NONE, 3, "sw_no_dep");
        v(0, 0, 1, sub_r6, 0, O_STALL, 3, "raw_gap_b1");
        v(0, 0, 1, sub_r6, 0, O_STALL, 4, "raw_gap_b2");
        v(0, 0, 1, sub_r6, 0, O_NONE, 5, "raw_gap_issue");
        v(0, 0, 1, ri(6'd10, 5'd1, 5'd0, 16'd3), 0, O_NONE, 5, "addi_r1");
        v(0, 0, 1, rr(6'd0, 5'd8, 5'd1, 5'd1), 1, O_FLUSH, 5, "br_over_hazard");
        v(0, 0, 1, rr(6'd0, 5'd9, 5'd1, 5'd0), 0, O_NONE, 5, "entry0_cleared");
        v(0, 0, 1, add_r10, 0, O_STALL, 5, "pre_rst_stall");
        v(0, 1, 1, add_r10, 0, O_NONE, 0, "async_rst");
        v(0, 0, 1, add_r10, 0, O_NONE, 0, "sb_empty_after_rst");
        v(0, 0, 1, ri(6'd10, 5'd11, 5'd0, 16'd1), 0, O_NONE, 0, "prog_addi1");
        v(0, 0, 1, ri(6'd10, 5'd12, 5'd0, 16'd2), 0, O_NONE, 0, "prog_addi2");
        v(0, 0, 1, ri(6'd10, 5'd13, 5'd0, 16'd3), 0, O_NONE, 0, "prog_addi3");
        v(0, 0, 1, hlt, 0, O_NONE, 0, "hlt_issue");
        v(0, 0, 1, add_r14, 0, O_STALL, 0, "drain1");
        v(0, 0, 1, add_r14, 0, O_STALL, 0, "drain2");
        v(0, 0, 1, add_r14, 0, O_STALL, 0, "drain3");
        v(0, 0, 1, add_r14, 0, O_HALT, 0, "halted");
        v(0, 0, 1, add_r14, 1, O_HALT, 0, "halt_ignores_br");
        v(0, 0, 1, add_r14, 0, O_HALT, 0, "halt_sticky");
        v(0, 1, 0, '0, 0, O_NONE, 0, "halt_rst");
        v(0, 0, 0, '0, 0, O_NONE, 0, "post_halt_idle");
        v(0, 0, 1, hlt, 0, O_NONE, 0, "wp_hlt_issue");
        v(0, 0, 1, rr(6'd0, 5'd2, 5'd0, 5'd0), 1, O_FLUSH, 0, "wp_hlt_branch");
        v(0, 0, 1, ri(6'd10, 5'd3, 5'd0, 16'd9), 0, O_NONE, 0, "target_issue");
        v(0, 0, 1, add_r4_r3, 0, O_STALL, 0, "target_raw1");
        v(0, 0, 1, add_r4_r3, 0, O_STALL, 1, "target_raw2");
        v(0, 0, 1, add_r4_r3, 0, O_STALL, 2, "target_raw3");
        v(0, 0, 1, add_r4_r3, 0, O_NONE, 3, "target_issue2");

        // WB_BYPASS=1, 2-bit counter instance
        v(1, 1, 0, '0, 0, O_NONE, 0, "byp_reset");
        v(1, 0, 0, '0, 0, O_NONE, 0, "byp_idle");
        v(1, 0, 1, ri(6'd10, 5'd2, 5'd0, 16'd20), 0, O_NONE, 0, "byp_addi_r2");
        v(1, 0, 1, add_r4_r1_r2, 0, O_STALL, 0, "byp_raw_b1");
        v(1, 0, 1, add_r4_r1_r2, 0, O_STALL, 1, "byp_raw_b2");
        v(1, 0, 1, add_r4_r1_r2, 0, O_NONE, 2, "byp_raw_issue");
        v(1, 0, 1, ri(6'd10, 5'd5, 5'd0, 16'd1), 0, O_NONE, 2, "byp_addi_r5");
        v(1, 0, 1, add_r6_r5, 0, O_STALL, 2, "byp_sat_b1");
        v(1, 0, 1, add_r6_r5, 0, O_STALL, 3, "byp_sat_b2");
        v(1, 0, 1, add_r6_r5, 0, O_NONE, 3, "byp_sat_hold");
        v(1, 0, 0, '0, 0, O_NONE, 3, "byp_final");

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            @(posedge clk);
            #1;
            apply(vecs[i]);
            e.which = vecs[i].which; e.idx = i; e.o = vecs[i].o;
            e.cnt = vecs[i].cnt; e.name = vecs[i].name;
            exp_q.push_back(e);
        end
        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_queue: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
